lii_out_arbiter: RTL and testbench
==================================

Name: lii_out_arbiter

Overview:
- Shares one LII phy output channel between NS logical kernel output streams.
- Uses round-robin arbitration with bounded bursts.
- Each accepted beat is zero-extended to PW and registered in a one-deep output stage, tagged with src (SRC_BASE+index) and that stream's dst.
- Sits between HLS kernel stream ports and the phy out channel when NOUT > Q.

Parameters:
- NS, 4, number of logical input streams (1..16)
- DW, 8, logical stream data width (DW <= PW)
- PW, 1024, phy packing width
- MAX_BURST, 16, max beats per grant (>= 1)
- SRC_BASE, 0, src tag of stream 0; stream i tags SRC_BASE+i (8-bit, wraps mod 256)

Ports:
- aclk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- in_tdata  in  NS*DW  stream i in bits [i*DW +: DW]
- in_tvalid  in  NS  per-stream valid
- in_tready  out  NS  per-stream ready
- in_dst  in  NS*8  destination tag per stream, sampled on acceptance
- lii_out_tdata  out  PW  packed beat
- lii_out_tvalid  out  1  beat valid
- lii_out_tready  in  1  phy ready
- lii_out_src  out  8  source tag of held beat
- lii_out_dst  out  8  destination tag of held beat
- grant  out  NS  one-hot current owner; 0 when idle
- busy  out  1  high in GRANT state

Behaviour:
- Reset (async assert, sync release) clears all of the following:
  - state = IDLE; grant = 0; rr_ptr = 0; beat_cnt = 0
  - lii_out_tvalid = 0; lii_out_tdata, src and dst = 0
  - in_tready = 0
- Reset mid-burst drops any beat held in the output register; no beat is emitted twice after reset.
- adv = !lii_out_tvalid | lii_out_tready. This means the output register may load this cycle.
- IDLE state:
  - in_tready = 0.
  - If any in_tvalid is set, pick the first i with in_tvalid[i] searching rr_ptr, rr_ptr+1, ... mod NS.
  - Set grant = onehot(i), beat_cnt = 0, and go to GRANT next cycle.
  - No request: stay in IDLE.
- GRANT state, owner k:
  - in_tready[k] = adv; all other in_tready bits = 0. This is combinational from lii_out_tready.
  - Accept = in_tvalid[k] & in_tready[k]. On accept, at the next edge:
    - lii_out_tdata <= zero-extended in_tdata[k]
    - lii_out_src <= SRC_BASE+k
    - lii_out_dst <= in_dst[k]
    - lii_out_tvalid <= 1
    - beat_cnt++
  - If adv & !accept: lii_out_tvalid <= 0.
  - If !adv: the output register holds. The phy contract requires tdata, src and dst to stay stable while tvalid=1 & tready=0.
- Release rules (ownership ends; return to IDLE; rr_ptr <= (k+1) mod NS):
  - (a) Accept when beat_cnt == MAX_BURST-1.
  - (b) in_tvalid[k] == 0 in any GRANT cycle. No transfer happens that cycle.
- The held output beat drains independently of the grant state.
- Latency:
  - Accept to lii_out_tvalid: 1 cycle.
  - Release to next grant: 1 IDLE cycle; the next GRANT starts 2 cycles after release.
  - Continuous throughput within a burst: 1 beat/cycle when lii_out_tready = 1.
- A single requester re-wins after its release. rr_ptr skips non-requesters, so it gets the grant again after the one IDLE bubble.
- Simultaneous requests: arbitration is strictly round-robin. No stream waits more than (NS-1) grants.
- NS = 1: grant is always bit 0; bursts still split at MAX_BURST.
- Ready never depends on in_tvalid (no combinational valid to ready path).

Test Plan:
- Single stream: NS=4, stream 2 sends bytes 0x11..0x14 (in_dst=0x05), lii_out_tready=1 throughout. Expect:
  - 4 output beats, 1-cycle latency
  - tdata[7:0] = 0x11..0x14, upper bits 0
  - src = 2, dst = 0x05
  - grant = 4'b0100 during the burst; rr_ptr = 3 after release.
- Round-robin: all four streams continuously valid, MAX_BURST=2. Expect:
  - grant order 0,1,2,3,0
  - each grant exactly 2 beats
  - src sequence 0,0,1,1,2,2,3,3
  - one IDLE bubble between grants.
- Backpressure: stream 0 bursts 0xA0..0xA3 while lii_out_tready is held low for 3 cycles mid-burst. Expect:
  - held beat stable (tdata, src, dst) while stalled
  - in_tready[0] = 0 during the stall
  - no loss or duplication; output order 0xA0..0xA3.
- Early release: stream 1 valid for 3 beats, then drops valid, with MAX_BURST=16. Expect:
  - 3 beats out
  - release on the invalid cycle
  - grant moves to requesting stream 3 next (rr_ptr = 2).
- Reset mid-burst: assert arstn=0 while lii_out_tvalid=1 and the beat is unaccepted. Expect immediately:
  - lii_out_tvalid = 0, grant = 0, in_tready = 0
  - after release, arbitration restarts from stream 0.
- SRC_BASE wrap: SRC_BASE=254, NS=4, stream 3 sends one beat. Expect lii_out_src = 0x01.

Source files
------------

// File: rtl/lii_out_arbiter.sv
// Round-robin arbiter sharing one LII phy output channel among NS kernel streams.
// Bursts are capped at MAX_BURST beats; accepted beats land in a one-deep output register.
module lii_out_arbiter #(
  parameter int unsigned NS        = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned PW        = 1024,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned SRC_BASE  = 0
) (
  input  logic               aclk,
  input  logic               arstn,
  input  logic [NS*DW-1:0]   in_tdata,
  input  logic [NS-1:0]      in_tvalid,
  output logic [NS-1:0]      in_tready,
  input  logic [NS*8-1:0]    in_dst,
  output logic [PW-1:0]      lii_out_tdata,
  output logic               lii_out_tvalid,
  input  logic               lii_out_tready,
  output logic [7:0]         lii_out_src,
  output logic [7:0]         lii_out_dst,
  output logic [NS-1:0]      grant,
  output logic               busy
);

  localparam int unsigned PTR_W = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       state, state_nx;
  logic [PTR_W-1:0] owner, owner_nx;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nx;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nx;
  logic [NS-1:0]    grant_nx;

  logic             adv;
  logic             accept;
  logic             last_beat;
  logic [PTR_W-1:0] next_ptr;
  logic             own_valid;
  logic [DW-1:0]    own_data;
  logic [7:0]       own_dst;
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;

  // Output register may load when empty or draining this cycle.
  assign adv       = !lii_out_tvalid | lii_out_tready;
  assign accept    = (state == S_GRANT) & own_valid & adv;
  assign last_beat = (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign next_ptr  = (owner == PTR_W'(NS - 1)) ? '0 : owner + PTR_W'(1);
  assign in_tready = ((state == S_GRANT) && adv) ? grant : '0;
  assign busy      = (state == S_GRANT);

  // Select the current owner's stream fields.
  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
    own_dst   = '0;
    for (int i = 0; i < NS; i++) begin
      if (owner == PTR_W'(i)) begin
        own_valid = in_tvalid[i];
        own_data  = in_tdata[i*DW +: DW];
        own_dst   = in_dst[i*8 +: 8];
      end
    end
  end

  // First requester at or after rr_ptr, wrapping modulo NS.
  always_comb begin
    int unsigned cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned off = 0; off < NS; off++) begin
      cand = 32'(rr_ptr) + off;
      if (cand >= NS) cand = cand - NS;
      if (!pick_found && in_tvalid[PTR_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    rr_ptr_nx   = rr_ptr;
    beat_cnt_nx = beat_cnt;
    grant_nx    = grant;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          state_nx    = S_GRANT;
          owner_nx    = pick_idx;
          grant_nx    = NS'(1) << pick_idx;
          beat_cnt_nx = '0;
        end
      end
      S_GRANT: begin
        if (!own_valid || (accept && last_beat)) begin
          state_nx    = S_IDLE;
          grant_nx    = '0;
          rr_ptr_nx   = next_ptr;
          beat_cnt_nx = '0;
        end else if (accept) begin
          beat_cnt_nx = beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state    <= S_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      grant    <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      rr_ptr   <= rr_ptr_nx;
      beat_cnt <= beat_cnt_nx;
      grant    <= grant_nx;
    end
  end

  // One-deep output stage; holds steady while the phy stalls.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      lii_out_tvalid <= 1'b0;
      lii_out_tdata  <= '0;
      lii_out_src    <= '0;
      lii_out_dst    <= '0;
    end else if (adv) begin
      lii_out_tvalid <= accept;
      if (accept) begin
        lii_out_tdata <= PW'(own_data);
        lii_out_src   <= 8'(SRC_BASE + 32'(owner));
        lii_out_dst   <= own_dst;
      end
    end
  end

endmodule

// File: tb/tb_lii_out_arbiter.sv
// Bench for lii_out_arbiter: two instances (MAX_BURST 16 / base 0, MAX_BURST 2 / base 254)
// checked by hand-derived vectors and a transaction-level reference model.
module tb_lii_out_arbiter;

  localparam int unsigned PW = 1024;

  logic        aclk = 1'b0;
  logic        arstn;
  logic [31:0] in_tdata;
  logic [3:0]  in_tvalid;
  logic [31:0] in_dst;
  logic        out_rdy;

  logic [3:0]    in_tready [2];
  logic [PW-1:0] o_tdata   [2];
  logic          o_tvalid  [2];
  logic [7:0]    o_src     [2];
  logic [7:0]    o_dst     [2];
  logic [3:0]    o_grant   [2];
  logic          o_busy    [2];

  int checks = 0;
  int errors = 0;

  // Reference model state: owner -1 means no stream holds the channel.
  int         m_owner [2];
  int         m_cnt   [2];
  int         m_rr    [2];
  bit         m_ov    [2];
  logic [7:0] m_data  [2];
  logic [7:0] m_src   [2];
  logic [7:0] m_dst   [2];

  logic [7:0] rx_d0 [$];
  logic [7:0] rx_s0 [$];
  logic [7:0] rx_s1 [$];

  always #5 aclk = ~aclk;

  lii_out_arbiter #(.NS(4), .DW(8), .PW(PW), .MAX_BURST(16), .SRC_BASE(0)) u_dut0 (
    .aclk(aclk), .arstn(arstn), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
    .in_tready(in_tready[0]), .in_dst(in_dst), .lii_out_tdata(o_tdata[0]),
    .lii_out_tvalid(o_tvalid[0]), .lii_out_tready(out_rdy), .lii_out_src(o_src[0]),
    .lii_out_dst(o_dst[0]), .grant(o_grant[0]), .busy(o_busy[0])
  );

  lii_out_arbiter #(.NS(4), .DW(8), .PW(PW), .MAX_BURST(2), .SRC_BASE(254)) u_dut1 (
    .aclk(aclk), .arstn(arstn), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
    .in_tready(in_tready[1]), .in_dst(in_dst), .lii_out_tdata(o_tdata[1]),
    .lii_out_tvalid(o_tvalid[1]), .lii_out_tready(out_rdy), .lii_out_src(o_src[1]),
    .lii_out_dst(o_dst[1]), .grant(o_grant[1]), .busy(o_busy[1])
  );

  typedef struct {
    logic [3:0]  v;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic        exp_tvalid;
    logic [7:0]  exp_byte;
    logic [3:0]  exp_grant;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic int max_burst(input int d);
    return (d == 0) ? 16 : 2;
  endfunction

  function automatic int src_base(input int d);
    return (d == 0) ? 0 : 254;
  endfunction

  function automatic logic [3:0] model_grant(input int d);
    return (m_owner[d] >= 0) ? 4'(1 << m_owner[d]) : 4'b0;
  endfunction

  function automatic logic [3:0] model_ready(input int d);
    return (m_owner[d] >= 0 && (!m_ov[d] || out_rdy)) ? model_grant(d) : 4'b0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_cnt[d] = 0; m_rr[d] = 0; m_ov[d] = 0;
      m_data[d] = '0;  m_src[d] = '0; m_dst[d] = '0;
    end
  endtask

  // One clock edge of the arbitration rules, expressed on stream indices.
  task automatic model_step(input int d);
    bit adv;
    bit found;
    int k;
    adv = !m_ov[d] || out_rdy;
    if (m_owner[d] < 0) begin
      if (adv) m_ov[d] = 0;
      found = 0;
      for (int o = 0; o < 4; o++) begin
        k = (m_rr[d] + o) % 4;
        if (!found && in_tvalid[k]) begin
          found = 1; m_owner[d] = k; m_cnt[d] = 0;
        end
      end
    end else begin
      k = m_owner[d];
      if (!in_tvalid[k]) begin
        if (adv) m_ov[d] = 0;
        m_rr[d] = (k + 1) % 4;
        m_owner[d] = -1;
      end else if (adv) begin
        m_ov[d]   = 1;
        m_data[d] = in_tdata[k*8 +: 8];
        m_src[d]  = 8'(src_base(d) + k);
        m_dst[d]  = in_dst[k*8 +: 8];
        m_cnt[d]++;
        if (m_cnt[d] == max_burst(d)) begin
          m_rr[d] = (k + 1) % 4;
          m_owner[d] = -1;
        end
      end
    end
  endtask

  task automatic check_outputs(input int d);
    check($sformatf("d%0d_tvalid", d), 64'(o_tvalid[d]), 64'(m_ov[d]));
    check($sformatf("d%0d_tdata_lo", d), o_tdata[d][63:0], 64'(m_data[d]));
    check($sformatf("d%0d_tdata_hi", d), 64'(|o_tdata[d][PW-1:64]), 64'(0));
    check($sformatf("d%0d_src", d), 64'(o_src[d]), 64'(m_src[d]));
    check($sformatf("d%0d_dst", d), 64'(o_dst[d]), 64'(m_dst[d]));
    check($sformatf("d%0d_grant", d), 64'(o_grant[d]), 64'(model_grant(d)));
    check($sformatf("d%0d_busy", d), 64'(o_busy[d]), 64'(m_owner[d] >= 0));
  endtask

  // Drive one cycle of inputs, check ready, clock, check registered outputs.
  task automatic step(input logic [3:0] v, input logic [31:0] data, input logic [31:0] dst,
                      input logic rdy, output logic [3:0] rdy0);
    in_tvalid = v; in_tdata = data; in_dst = dst; out_rdy = rdy;
    #1;
    rdy0 = in_tready[0];
    for (int d = 0; d < 2; d++)
      check($sformatf("d%0d_in_tready", d), 64'(in_tready[d]), 64'(model_ready(d)));
    if (o_tvalid[0] && out_rdy) begin
      rx_d0.push_back(o_tdata[0][7:0]);
      rx_s0.push_back(o_src[0]);
    end
    if (o_tvalid[1] && out_rdy) rx_s1.push_back(o_src[1]);
    @(posedge aclk);
    for (int d = 0; d < 2; d++) model_step(d);
    #1;
    for (int d = 0; d < 2; d++) check_outputs(d);
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_d%0d_tvalid", tag, d), 64'(o_tvalid[d]), 64'(0));
      check($sformatf("%s_d%0d_grant", tag, d), 64'(o_grant[d]), 64'(0));
      check($sformatf("%s_d%0d_in_tready", tag, d), 64'(in_tready[d]), 64'(0));
      check($sformatf("%s_d%0d_tdata", tag, d), 64'(|o_tdata[d]), 64'(0));
      check($sformatf("%s_d%0d_src_dst", tag, d), 64'({o_src[d], o_dst[d]}), 64'(0));
      check($sformatf("%s_d%0d_busy", tag, d), 64'(o_busy[d]), 64'(0));
    end
  endtask

  // Assert reset off-edge, check the immediate effect, release on a falling edge.
  task automatic do_reset(input string tag);
    arstn = 1'b0;
    #1;
    model_reset();
    check_reset_state(tag);
    in_tvalid = '0; in_tdata = '0; in_dst = '0; out_rdy = 1'b1;
    @(negedge aclk);
    arstn = 1'b1;
    @(posedge aclk);
    #1;
    rx_d0.delete(); rx_s0.delete(); rx_s1.delete();
  endtask

  initial begin
    vec_t        tbl [8];
    logic [3:0]  r0;
    logic [3:0]  v;
    logic [3:0]  prev_g;
    logic [3:0]  gseq [$];
    logic [7:0]  exp_s1 [8];
    logic [3:0]  exp_g [5];
    int          idx;
    int          n1;
    int          ones;

    // Single stream 2, bytes 0x11..0x14, then a 0/3 request to expose rr_ptr = 3.
    tbl[0] = '{4'b0100, 32'h0011_0000, 4'b0000, 1'b0, 8'h00, 4'b0100};
    tbl[1] = '{4'b0100, 32'h0011_0000, 4'b0100, 1'b1, 8'h11, 4'b0100};
    tbl[2] = '{4'b0100, 32'h0012_0000, 4'b0100, 1'b1, 8'h12, 4'b0100};
    tbl[3] = '{4'b0100, 32'h0013_0000, 4'b0100, 1'b1, 8'h13, 4'b0100};
    tbl[4] = '{4'b0100, 32'h0014_0000, 4'b0100, 1'b1, 8'h14, 4'b0100};
    tbl[5] = '{4'b0000, 32'h0000_0000, 4'b0100, 1'b0, 8'h00, 4'b0000};
    tbl[6] = '{4'b1001, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 4'b1000};
    tbl[7] = '{4'b0000, 32'h0000_0000, 4'b1000, 1'b0, 8'h00, 4'b0000};
    exp_s1 = '{8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h01};
    exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    arstn = 1'b0; in_tvalid = '0; in_tdata = '0; in_dst = '0; out_rdy = 1'b1;
    model_reset();
    repeat (2) @(posedge aclk);
    do_reset("por");

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].data, 32'h0005_0000, 1'b1, r0);
      check($sformatf("tbl%0d_ready", i), 64'(r0), 64'(tbl[i].exp_ready));
      check($sformatf("tbl%0d_tvalid", i), 64'(o_tvalid[0]), 64'(tbl[i].exp_tvalid));
      check($sformatf("tbl%0d_grant", i), 64'(o_grant[0]), 64'(tbl[i].exp_grant));
      if (tbl[i].exp_tvalid) begin
        check($sformatf("tbl%0d_tdata", i), o_tdata[0][63:0], 64'(tbl[i].exp_byte));
        check($sformatf("tbl%0d_src", i), 64'(o_src[0]), 64'(8'd2));
        check($sformatf("tbl%0d_dst", i), 64'(o_dst[0]), 64'(8'h05));
      end
    end

    // Round robin on the MAX_BURST=2 instance; its sources wrap past 255.
    do_reset("rr");
    prev_g = '0;
    for (int c = 0; c < 14; c++) begin
      step(4'hF, 32'h4433_2211 + 32'(c), 32'h0D0C_0B0A, 1'b1, r0);
      if (o_grant[1] != 4'b0 && prev_g == 4'b0) gseq.push_back(o_grant[1]);
      prev_g = o_grant[1];
    end
    check("rr_beats", 64'(rx_s1.size() >= 8), 64'(1));
    for (int i = 0; i < 8 && i < rx_s1.size(); i++)
      check($sformatf("rr_src%0d", i), 64'(rx_s1[i]), 64'(exp_s1[i]));
    check("rr_grants", 64'(gseq.size() >= 5), 64'(1));
    for (int i = 0; i < 5 && i < gseq.size(); i++)
      check($sformatf("rr_grant%0d", i), 64'(gseq[i]), 64'(exp_g[i]));

    // Backpressure: phy stalls three cycles while A1 is held.
    do_reset("bp");
    idx = 0;
    for (int j = 0; j < 12; j++) begin
      v = (idx < 4) ? 4'b0001 : 4'b0000;
      step(v, 32'(8'hA0 + idx), 32'h0000_003C, !(j >= 3 && j < 6), r0);
      if (v[0] && r0[0]) idx++;
      if (j >= 3 && j < 6) begin
        check($sformatf("bp_stall%0d_ready", j), 64'(r0[0]), 64'(0));
        check($sformatf("bp_stall%0d_tvalid", j), 64'(o_tvalid[0]), 64'(1));
        check($sformatf("bp_stall%0d_tdata", j), o_tdata[0][63:0], 64'(8'hA1));
        check($sformatf("bp_stall%0d_srcdst", j), 64'({o_src[0], o_dst[0]}), 64'(16'h003C));
      end
    end
    check("bp_count", 64'(rx_d0.size()), 64'(4));
    for (int i = 0; i < 4 && i < rx_d0.size(); i++)
      check($sformatf("bp_beat%0d", i), 64'(rx_d0[i]), 64'(8'hA0 + i));

    // Early release: stream 1 sends 3 beats then drops; stream 3 waits.
    do_reset("er");
    n1 = 0;
    for (int j = 0; j < 10; j++) begin
      v = {1'b1, 1'b0, (n1 < 3), 1'b0};
      step(v, {8'hD0 + 8'(j), 8'h00, 8'hB0 + 8'(n1), 8'h00}, 32'h7700_6600, 1'b1, r0);
      if (v[1] && r0[1]) n1++;
      if (j == 4) check("er_release_grant", 64'(o_grant[0]), 64'(4'b0000));
      if (j == 5) check("er_next_grant", 64'(o_grant[0]), 64'(4'b1000));
    end
    ones = 0;
    foreach (rx_s0[i]) if (rx_s0[i] == 8'd1) ones++;
    check("er_stream1_beats", 64'(ones), 64'(3));

    // Reset mid-burst with an unaccepted beat held; rr_ptr was 2 beforehand.
    step(4'b1000, 32'hE100_0000, 32'h7700_0000, 1'b0, r0);
    step(4'b1000, 32'hE200_0000, 32'h7700_0000, 1'b0, r0);
    check("mid_held_tvalid", 64'(o_tvalid[0]), 64'(1));
    do_reset("mid");
    step(4'b0101, 32'h0033_0044, 32'h0000_0000, 1'b1, r0);
    check("mid_restart_grant", 64'(o_grant[0]), 64'(4'b0001));
    step(4'b0101, 32'h0033_0044, 32'h0000_0000, 1'b1, r0);
    step(4'b0000, 32'h0, 32'h0, 1'b1, r0);
    check("mid_single_beat", 64'(rx_d0.size()), 64'(1));

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) v[b] = ($urandom_range(0, 9) < 7);
      step(v, $urandom, $urandom, ($urandom_range(0, 3) != 0), r0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
